// File: rtl/piarb_rr_credit_sch.sv
// rtl/piarb_rr_credit_sch.sv - round-robin credit-gated dequeue scheduler for the PU queue manager
// Tracks non-empty/pending/credit per queue and issues at most one registered deq_req per cycle.
module piarb_rr_credit_sch #(
  parameter int QUEUE_ID_NBITS = 5,
  parameter int QUEUE_DEPTH    = 16,
  parameter int CREDIT_NBITS   = 3,
  parameter int CREDIT_INIT    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enq_ack,
  input  logic                      enq_to_empty,
  input  logic [QUEUE_ID_NBITS-1:0] enq_ack_qid,
  input  logic                      deq_depth_ack,
  input  logic                      deq_depth_from_emptyp2,
  input  logic [QUEUE_ID_NBITS-1:0] deq_depth_ack_qid,
  input  logic                      credit_ret,
  input  logic [QUEUE_ID_NBITS-1:0] credit_ret_qid,
  output logic                      deq_req,
  output logic [QUEUE_ID_NBITS-1:0] deq_qid,
  output logic                      err_spurious_ack
);

  localparam logic [CREDIT_NBITS-1:0]   CREDIT_MAX = '1;
  localparam logic [CREDIT_NBITS-1:0]   CREDIT_RST = CREDIT_NBITS'(CREDIT_INIT);
  localparam logic [QUEUE_ID_NBITS-1:0] RR_RST     = QUEUE_ID_NBITS'(QUEUE_DEPTH - 1);

  logic [QUEUE_DEPTH-1:0]    active_q, active_d;
  logic [QUEUE_DEPTH-1:0]    pending_q, pending_d;
  logic [CREDIT_NBITS-1:0]   credit_q [QUEUE_DEPTH];
  logic [CREDIT_NBITS-1:0]   credit_d [QUEUE_DEPTH];
  logic [QUEUE_ID_NBITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                      deq_req_q, deq_req_d;
  logic [QUEUE_ID_NBITS-1:0] deq_qid_q, deq_qid_d;
  logic                      err_q, err_d;

  logic [QUEUE_DEPTH-1:0]    eligible;
  logic [QUEUE_DEPTH-1:0]    enq_set;
  logic [QUEUE_DEPTH-1:0]    ack_hit;
  logic [QUEUE_DEPTH-1:0]    ret_hit;
  logic [QUEUE_DEPTH-1:0]    grant_vec;
  logic                      grant;
  logic [QUEUE_ID_NBITS-1:0] win_qid;

  // Id decode by equality against every real queue, so ids >= QUEUE_DEPTH never match.
  always_comb begin
    enq_set  = '0;
    ack_hit  = '0;
    ret_hit  = '0;
    eligible = '0;
    for (int q = 0; q < QUEUE_DEPTH; q++) begin
      enq_set[q]  = enq_ack && enq_to_empty && (enq_ack_qid == QUEUE_ID_NBITS'(q));
      ack_hit[q]  = deq_depth_ack && (deq_depth_ack_qid == QUEUE_ID_NBITS'(q));
      ret_hit[q]  = credit_ret && (credit_ret_qid == QUEUE_ID_NBITS'(q));
      eligible[q] = active_q[q] && !pending_q[q] && (credit_q[q] != '0);
    end
  end

  // Winner is the eligible queue with the smallest distance past rr_ptr.
  always_comb begin
    int best_off;
    int off;
    grant    = 1'b0;
    win_qid  = '0;
    best_off = QUEUE_DEPTH;
    off      = 0;
    for (int q = 0; q < QUEUE_DEPTH; q++) begin
      off = (q + QUEUE_DEPTH - 1 - int'(rr_ptr_q)) % QUEUE_DEPTH;
      if (eligible[q] && (off < best_off)) begin
        best_off = off;
        win_qid  = QUEUE_ID_NBITS'(q);
        grant    = 1'b1;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int q = 0; q < QUEUE_DEPTH; q++) begin
      grant_vec[q] = grant && (win_qid == QUEUE_ID_NBITS'(q));
    end
  end

  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    for (int q = 0; q < QUEUE_DEPTH; q++) begin
      credit_d[q] = credit_q[q];
      if (ack_hit[q]) begin
        pending_d[q] = 1'b0;
        active_d[q]  = deq_depth_from_emptyp2;
        if (!pending_q[q]) begin
          err_d = 1'b1;
        end
      end
      // An enqueue into an empty queue overrides a same-cycle drain to empty.
      if (enq_set[q]) begin
        active_d[q] = 1'b1;
      end
      if (grant_vec[q]) begin
        pending_d[q] = 1'b1;
      end
      if (ret_hit[q] && !grant_vec[q]) begin
        if (credit_q[q] != CREDIT_MAX) begin
          credit_d[q] = credit_q[q] + 1'b1;
        end
      end else if (grant_vec[q] && !ret_hit[q]) begin
        credit_d[q] = credit_q[q] - 1'b1;
      end
    end
    deq_req_d = grant;
    deq_qid_d = grant ? win_qid : deq_qid_q;
    rr_ptr_d  = grant ? win_qid : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      pending_q <= '0;
      rr_ptr_q  <= RR_RST;
      deq_req_q <= 1'b0;
      deq_qid_q <= '0;
      err_q     <= 1'b0;
      for (int q = 0; q < QUEUE_DEPTH; q++) begin
        credit_q[q] <= CREDIT_RST;
      end
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      deq_req_q <= deq_req_d;
      deq_qid_q <= deq_qid_d;
      err_q     <= err_d;
      for (int q = 0; q < QUEUE_DEPTH; q++) begin
        credit_q[q] <= credit_d[q];
      end
    end
  end

  assign deq_req          = deq_req_q;
  assign deq_qid          = deq_qid_q;
  assign err_spurious_ack = err_q;

endmodule

// File: tb/tb_piarb_rr_credit_sch.sv
// tb/tb_piarb_rr_credit_sch.sv - self-checking bench for piarb_rr_credit_sch
// Directed scenarios plus random traffic, all compared every cycle against a behavioural model.
module tb_piarb_rr_credit_sch;

  localparam int QD   = 16;
  localparam int QIDW = 5;
  localparam int CMAX = 7;
  localparam int CINI = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enq_ack = 1'b0;
  logic            enq_to_empty = 1'b0;
  logic [QIDW-1:0] enq_ack_qid = '0;
  logic            deq_depth_ack = 1'b0;
  logic            deq_depth_from_emptyp2 = 1'b0;
  logic [QIDW-1:0] deq_depth_ack_qid = '0;
  logic            credit_ret = 1'b0;
  logic [QIDW-1:0] credit_ret_qid = '0;
  logic            deq_req;
  logic [QIDW-1:0] deq_qid;
  logic            err_spurious_ack;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_active [QD];
  int m_pending[QD];
  int m_credit [QD];
  int m_rr;
  int m_req, m_qid, m_err;

  int grant_log[$];
  int outq[$];

  piarb_rr_credit_sch dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enq_ack                (enq_ack),
    .enq_to_empty           (enq_to_empty),
    .enq_ack_qid            (enq_ack_qid),
    .deq_depth_ack          (deq_depth_ack),
    .deq_depth_from_emptyp2 (deq_depth_from_emptyp2),
    .deq_depth_ack_qid      (deq_depth_ack_qid),
    .credit_ret             (credit_ret),
    .credit_ret_qid         (credit_ret_qid),
    .deq_req                (deq_req),
    .deq_qid                (deq_qid),
    .err_spurious_ack       (err_spurious_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: scan forward from the last winner; ret+grant on one queue cancel out.
  task automatic model_step();
    int w;
    int aq, eq, rq;
    if (!rst_n) begin
      for (int q = 0; q < QD; q++) begin
        m_active[q] = 0; m_pending[q] = 0; m_credit[q] = CINI;
      end
      m_rr = QD - 1; m_req = 0; m_qid = 0; m_err = 0;
      return;
    end
    w = -1;
    for (int k = 1; k <= QD; k++) begin
      int c;
      c = (m_rr + k) % QD;
      if (w < 0 && m_active[c] != 0 && m_pending[c] == 0 && m_credit[c] > 0) w = c;
    end
    aq = int'(deq_depth_ack_qid);
    eq = int'(enq_ack_qid);
    rq = int'(credit_ret_qid);
    m_err = 0;
    if (deq_depth_ack && aq < QD) begin
      if (m_pending[aq] == 0) m_err = 1;
      m_pending[aq] = 0;
      m_active[aq]  = deq_depth_from_emptyp2 ? 1 : 0;
    end
    if (enq_ack && enq_to_empty && eq < QD) m_active[eq] = 1;
    if (credit_ret && rq < QD && rq != w) begin
      if (m_credit[rq] < CMAX) m_credit[rq]++;
    end
    m_req = (w >= 0) ? 1 : 0;
    if (w >= 0) begin
      m_qid = w;
      m_pending[w] = 1;
      m_rr = w;
      if (!(credit_ret && rq == w)) m_credit[w]--;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("deq_req", int'(deq_req), m_req);
        if (m_req != 0 && deq_req) chk("deq_qid", int'(deq_qid), m_qid);
        chk("err_spurious_ack", int'(err_spurious_ack), m_err);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (deq_req) grant_log.push_back(int'(deq_qid));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    enq_ack = 0; enq_to_empty = 0; enq_ack_qid = '0;
    deq_depth_ack = 0; deq_depth_from_emptyp2 = 0; deq_depth_ack_qid = '0;
    credit_ret = 0; credit_ret_qid = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    grant_log.delete();
    outq.delete();
  endtask

  task automatic enq(input int q);
    enq_ack = 1; enq_to_empty = 1; enq_ack_qid = QIDW'(q);
  endtask

  // mode 1: ack drains the queue, mode 2: ack leaves it non-empty
  task automatic ack_if(input int mode);
    if (deq_req) begin
      deq_depth_ack = 1;
      deq_depth_ack_qid = deq_qid;
      deq_depth_from_emptyp2 = (mode == 2);
    end
  endtask

  initial begin
    bit seen;
    int pat[3];
    rst_n = 1;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    chk("reset_deq_req", int'(deq_req), 0);
    chk("reset_deq_qid", int'(deq_qid), 0);
    chk("reset_err", int'(err_spurious_ack), 0);

    // 1: single enqueue, one dequeue, latency pinned
    do_reset();
    cyc(); enq(3);
    cyc(); chk("t1_no_req_yet", int'(deq_req), 0);
    cyc(); chk("t1_req", int'(deq_req), 1); chk("t1_qid", int'(deq_qid), 3);
    ack_if(1);
    repeat (10) cyc();
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_credit3", m_credit[3], 3);

    // 2: three queues served round robin until credits run out
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc(); ack_if(2);
      if (i == 0) enq(1);
      if (i == 1) enq(5);
      if (i == 2) enq(9);
    end
    chk("t2_grants", grant_log.size(), 12);
    pat[0] = 1; pat[1] = 5; pat[2] = 9;
    for (int i = 0; i < grant_log.size() && i < 12; i++)
      chk("t2_order", grant_log[i], pat[i % 3]);
    chk("t2_idle", int'(deq_req), 0);

    // 3: exhausted queue skipped until one credit comes back
    do_reset();
    cyc(); enq(7);
    for (int i = 0; i < 20; i++) begin cyc(); ack_if(2); end
    chk("t3_grants_before", grant_log.size(), 4);
    cyc(); ack_if(2); credit_ret = 1; credit_ret_qid = 7;
    for (int i = 0; i < 20; i++) begin cyc(); ack_if(2); end
    chk("t3_grants_after", grant_log.size(), 5);
    chk("t3_last_qid", grant_log[grant_log.size()-1], 7);

    // 4: drain-ack and enqueue-to-empty on the same queue in one cycle
    do_reset();
    cyc(); enq(2);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      if (deq_req) seen = 1;
    end
    chk("t4_first_grant", int'(seen), 1);
    deq_depth_ack = 1; deq_depth_ack_qid = 2; deq_depth_from_emptyp2 = 0;
    enq(2);
    grant_log.delete();
    repeat (6) cyc();
    chk("t4_regrant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("t4_regrant_qid", grant_log[0], 2);

    // 5: ack for a queue with nothing outstanding
    do_reset();
    cyc(); deq_depth_ack = 1; deq_depth_ack_qid = 4; deq_depth_from_emptyp2 = 0;
    cyc(); chk("t5_err_pulse", int'(err_spurious_ack), 1); chk("t5_no_req", int'(deq_req), 0);
    cyc(); chk("t5_err_clear", int'(err_spurious_ack), 0);

    // 6: credit saturation, then reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) begin cyc(); credit_ret = 1; credit_ret_qid = 0; end
    cyc();
    chk("t6_credit_sat", m_credit[0], 7);
    enq(0);
    for (int i = 0; i < 40; i++) begin cyc(); ack_if(2); end
    chk("t6_sat_grants", grant_log.size(), 7);

    do_reset();
    cyc(); enq(0);
    cyc();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #2;
      if (deq_req) seen = 1;
    end
    chk("t6_req_before_rst", int'(seen), 1);
    rst_n = 0;
    #1 chk("t6_rst_drop", int'(deq_req), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    grant_log.delete();
    cyc(); enq(0);
    for (int i = 0; i < 30; i++) begin cyc(); ack_if(2); end
    chk("t6_grants_after_rst", grant_log.size(), 4);

    // random traffic, including out-of-range ids and stray acks
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (deq_req) outq.push_back(int'(deq_qid));
      if (outq.size() > 0 && $urandom_range(0, 2) == 0) begin
        deq_depth_ack = 1;
        deq_depth_ack_qid = QIDW'(outq.pop_front());
        deq_depth_from_emptyp2 = 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 39) == 0) begin
        deq_depth_ack = 1;
        deq_depth_ack_qid = QIDW'($urandom_range(0, QD + 1));
        deq_depth_from_emptyp2 = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        enq_ack = 1;
        enq_to_empty = 1'($urandom_range(0, 1));
        enq_ack_qid = QIDW'($urandom_range(0, QD + 1));
      end
      if ($urandom_range(0, 4) == 0) begin
        credit_ret = 1;
        credit_ret_qid = QIDW'($urandom_range(0, QD + 1));
      end
    end
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
